pcm_pdm_tx: RTL and testbench
=============================

Name: pcm_pdm_tx

Overview:
Speaker-path counterpart of the microphone PDM decoder. Accepts 16-bit signed PCM samples at about 48 kHz through a valid/ready interface and buffers them in a small FIFO. A first-order sigma-delta modulator turns each sample into a 1-bit PDM stream for the board's audio amplifier. Sits between the audio-generation/playback logic and the top-level aud_pwm/aud_sd pins; top level converts pdm_o to open-drain (0 drives low, 1 releases to Z).

Parameters:
CLK_DIV, 32, clk_i cycles per PDM bit (100 MHz/32 = 3.125 MHz bit rate)
OSR, 64, PDM bits per PCM sample (frame)
FIFO_DEPTH, 4, PCM sample buffer entries (power of 2)
PRIME_LEVEL, 2, FIFO entries required before leaving PRIME

Ports:
clk_i  in  1  100 MHz system clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  1 = play, 0 = mute and flush
data_spk  in  16  signed two's-complement PCM sample
data_spk_valid  in  1  sample strobe, one clk_i cycle per sample
data_spk_ready  out  1  FIFO can accept a sample this cycle
pdm_o  out  1  PDM bitstream, registered
aud_sd_o  out  1  amplifier enable (1 = on)
underrun_o  out  1  sticky: frame boundary hit with FIFO empty in RUN
overflow_o  out  1  sticky: valid asserted while not ready
clr_flags_i  in  1  synchronous clear of both sticky flags
fifo_level_o  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_ni=0). All outputs are 0: pdm_o, aud_sd_o, data_spk_ready, underrun_o, overflow_o, fifo_level_o. Accumulator acc=0, u_cur=0x8000, state=MUTE, counters=0.
- Bit tick: div_cnt counts 0..CLK_DIV-1 and wraps. tick is asserted on the cycle where div_cnt==CLK_DIV-1. div_cnt runs only outside MUTE; MUTE holds it at 0.
- Frame counter: frm_cnt advances on each tick, 0..OSR-1, then wraps. A frame boundary is a tick with frm_cnt==OSR-1.
- Offset conversion: u = data ^ 16'h8000 (unsigned; 0x8000 is silence).
- Modulator, on each tick outside MUTE: {carry, acc} <= acc + u_cur (17-bit sum), then pdm_o <= carry. Ones density is u_cur/65536.
- FIFO:
  - Push when data_spk_valid && data_spk_ready.
  - data_spk_ready = (state!=MUTE) && (level<FIFO_DEPTH).
  - A push and a pop in the same cycle leave the level unchanged.
  - data_spk_valid while ready=0 and state!=MUTE sets overflow_o; the sample is dropped.
- States:
  - MUTE: aud_sd_o=0, pdm_o forced 0, FIFO flushed (level=0), acc=0, u_cur=0x8000, writes ignored, no flags set. Goes to PRIME on the cycle after enable_i=1.
  - PRIME: aud_sd_o=1; modulates u_cur=0x8000 (alternating 0,1); no pops. On a frame boundary with level>=PRIME_LEVEL: pop the head into u_cur and go to RUN.
  - RUN: on each frame boundary, pop the head into u_cur. If the FIFO is empty at that boundary, keep u_cur, set underrun_o and stay in RUN.
  - Any state with enable_i=0: go to MUTE the next cycle, abandoning any frame in progress.
- Latency: a popped sample affects the pdm_o bit produced on the next tick (OSR-bit frame granularity).
- Flags: clr_flags_i clears both flags. If a set and a clear happen in the same cycle, set wins.
- fifo_level_o is the registered occupancy.
- No arithmetic saturation is needed: u ranges 0..0xFFFF and the 17-bit sum cannot overflow.

Test Plan:
- Reset, enable_i=1, feed 0x0000 (u=0x8000) ×4 at 48 kHz -> aud_sd_o=1 next cycle; RUN entered at first boundary with level>=2; pdm_o alternates 0,1,0,1 on every tick.
- Feed constant 0x4000 (u=0xC000), start acc=0 -> pdm_o repeats 0,1,1,1; ones count over one 64-bit frame = 48.
- Feed 0x8000 (u=0) -> pdm_o all 0. Feed 0x7FFF -> first bit 0, then 1s: 63 ones in the first frame.
- Push 5 samples back-to-back with no pops (PRIME, level<PRIME_LEVEL never popped early) -> pushes 1-4 accepted, data_spk_ready=0 at level 4, overflow_o=1 after the 5th; clr_flags_i -> overflow_o=0.
- In RUN, stop feeding -> first boundary with empty FIFO sets underrun_o=1; u_cur holds the last sample; pdm_o pattern unchanged.
- Drop enable_i mid-frame -> next cycle: MUTE, pdm_o=0, aud_sd_o=0, level=0, ready=0. Assert rst_ni=0 asynchronously mid-tick -> all outputs 0 immediately, with no clock edge.

Source files
------------

// File: rtl/pcm_pdm_tx.sv
`default_nettype none
// ============================================================================
// Module   : pcm_pdm_tx
// Purpose  : PCM sample FIFO feeding a first-order sigma-delta PDM modulator.
// Revision : 1.0
// ============================================================================
module pcm_pdm_tx #(
    parameter int CLK_DIV     = 32,
    parameter int OSR         = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int PRIME_LEVEL = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic [15:0]                   data_spk,
    input  logic                          data_spk_valid,
    output logic                          data_spk_ready,
    output logic                          pdm_o,
    output logic                          aud_sd_o,
    output logic                          underrun_o,
    output logic                          overflow_o,
    input  logic                          clr_flags_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_FRM_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_MUTE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [c_DIV_W-1:0]   r_div_cnt;
    logic [c_FRM_W-1:0]   r_frm_cnt;
    logic [15:0]          r_acc;
    logic [15:0]          r_u_cur;
    logic                 r_pdm;
    logic                 r_underrun;
    logic                 r_overflow;
    logic [c_LVL_W-1:0]   r_level;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [15:0]          r_mem [FIFO_DEPTH];

    logic                 w_active;
    logic                 w_tick;
    logic                 w_boundary;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_underrun_set;
    logic                 w_overflow_set;
    logic [16:0]          w_sum;

    // Dropping enable flushes on the very next edge, so it gates all activity.
    assign w_active       = (r_state != ST_MUTE) && enable_i;
    assign w_tick         = w_active && (r_div_cnt == c_DIV_W'(CLK_DIV - 1));
    assign w_boundary     = w_tick && (r_frm_cnt == c_FRM_W'(OSR - 1));
    assign w_sum          = {1'b0, r_acc} + {1'b0, r_u_cur};

    assign data_spk_ready = (r_state != ST_MUTE) && (r_level < c_LVL_W'(FIFO_DEPTH));
    assign w_push         = data_spk_valid && data_spk_ready;
    assign w_overflow_set = data_spk_valid && !data_spk_ready && (r_state != ST_MUTE);

    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_underrun_set = 1'b0;
        if (!enable_i) begin
            w_state_nxt = ST_MUTE;
        end else begin
            case (r_state)
                ST_MUTE: begin
                    w_state_nxt = ST_PRIME;
                end
                ST_PRIME: begin
                    if (w_boundary && (r_level >= c_LVL_W'(PRIME_LEVEL))) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_boundary) begin
                        if (r_level != '0) begin
                            w_pop = 1'b1;
                        end else begin
                            w_underrun_set = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_MUTE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_MUTE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div_cnt  <= '0;
            r_frm_cnt  <= '0;
            r_acc      <= '0;
            r_u_cur    <= 16'h8000;
            r_pdm      <= 1'b0;
            r_level    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (!w_active) begin
                r_div_cnt <= '0;
                r_frm_cnt <= '0;
                r_acc     <= '0;
                r_u_cur   <= 16'h8000;
                r_pdm     <= 1'b0;
                r_level   <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
            end else begin
                if (w_tick) begin
                    r_div_cnt      <= '0;
                    r_frm_cnt      <= w_boundary ? '0 : r_frm_cnt + c_FRM_W'(1);
                    {r_pdm, r_acc} <= w_sum;
                end else begin
                    r_div_cnt <= r_div_cnt + c_DIV_W'(1);
                end
                // Stored samples are signed; the modulator wants offset binary.
                if (w_pop) begin
                    r_u_cur  <= r_mem[r_rd_ptr] ^ 16'h8000;
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                r_level <= r_level + c_LVL_W'(w_push) - c_LVL_W'(w_pop);
            end
            r_underrun <= w_underrun_set || (r_underrun && !clr_flags_i);
            r_overflow <= w_overflow_set || (r_overflow && !clr_flags_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && w_active) begin
            r_mem[r_wr_ptr] <= data_spk;
        end
    end

    assign pdm_o        = r_pdm;
    assign aud_sd_o     = (r_state != ST_MUTE);
    assign underrun_o   = r_underrun;
    assign overflow_o   = r_overflow;
    assign fifo_level_o = r_level;

endmodule
`default_nettype wire

// File: tb/tb_pcm_pdm_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcm_pdm_tx
// Purpose  : Directed bench for pcm_pdm_tx with a per-cycle reference model.
// Revision : 1.0
// ============================================================================
module tb_pcm_pdm_tx;

    localparam int CLK_DIV     = 32;
    localparam int OSR         = 64;
    localparam int FIFO_DEPTH  = 4;
    localparam int PRIME_LEVEL = 2;

    logic        clk;
    logic        rst_ni;
    logic        en;
    logic [15:0] data;
    logic        valid;
    logic        clr;
    logic        ready;
    logic        pdm;
    logic        aud_sd;
    logic        unf;
    logic        ovf;
    logic [2:0]  level;

    int n_tests = 0;
    int n_fail  = 0;

    pcm_pdm_tx #(
        .CLK_DIV     (CLK_DIV),
        .OSR         (OSR),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .PRIME_LEVEL (PRIME_LEVEL)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .enable_i       (en),
        .data_spk       (data),
        .data_spk_valid (valid),
        .data_spk_ready (ready),
        .pdm_o          (pdm),
        .aud_sd_o       (aud_sd),
        .underrun_o     (unf),
        .overflow_o     (ovf),
        .clr_flags_i    (clr),
        .fifo_level_o   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: state 0=mute 1=prime 2=run, time measured in cycles
    // since leaving mute, modulator as plain integer arithmetic.
    int          m_st;
    int          m_cyc;
    int          m_ticks;
    int          m_acc;
    int          m_u;
    bit          m_pdm;
    bit          m_unf;
    bit          m_ovf;
    bit          m_tick_flag;
    int          m_tick_idx;
    logic [15:0] m_q[$];
    int          bits[1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_flush();
        m_st    = 0;
        m_cyc   = 0;
        m_ticks = 0;
        m_acc   = 0;
        m_u     = 32768;
        m_pdm   = 1'b0;
        m_q.delete();
        for (int i = 0; i < 1024; i++) bits[i] = -1;
    endtask

    task automatic model_reset();
        model_flush();
        m_unf       = 1'b0;
        m_ovf       = 1'b0;
        m_tick_flag = 1'b0;
    endtask

    task automatic model_step();
        bit rdy;
        bit oset;
        bit uset;
        bit tick;
        bit bnd;
        int s;
        m_tick_flag = 1'b0;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        rdy  = (m_st != 0) && (m_q.size() < FIFO_DEPTH);
        oset = valid && !rdy && (m_st != 0);
        uset = 1'b0;
        if (!en) begin
            model_flush();
        end else if (m_st == 0) begin
            model_flush();
            m_st = 1;
        end else begin
            tick = (m_cyc % CLK_DIV) == CLK_DIV - 1;
            bnd  = tick && ((m_ticks % OSR) == OSR - 1);
            if (tick) begin
                s            = m_acc + m_u;
                m_pdm        = (s >= 65536);
                m_acc        = s % 65536;
                m_tick_idx   = m_ticks;
                m_tick_flag  = 1'b1;
                m_ticks++;
            end
            if (bnd) begin
                if (m_st == 1 && m_q.size() >= PRIME_LEVEL) begin
                    m_u  = 32'(m_q.pop_front());
                    m_st = 2;
                end else if (m_st == 2) begin
                    if (m_q.size() > 0) m_u = 32'(m_q.pop_front());
                    else uset = 1'b1;
                end
            end
            if (valid && rdy) m_q.push_back(data ^ 16'h8000);
            m_cyc++;
        end
        m_unf = uset || (m_unf && !clr);
        m_ovf = oset || (m_ovf && !clr);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every falling edge: record the bit of a fresh tick, then compare all outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (m_tick_flag && m_tick_idx < 1024) bits[m_tick_idx] = 32'(pdm);
            check("pdm_o",          32'(pdm),    32'(m_pdm));
            check("aud_sd_o",       32'(aud_sd), 32'(m_st != 0));
            check("data_spk_ready", 32'(ready),  32'((m_st != 0) && (m_q.size() < FIFO_DEPTH)));
            check("fifo_level_o",   32'(level),  32'(m_q.size()));
            check("underrun_o",     32'(unf),    32'(m_unf));
            check("overflow_o",     32'(ovf),    32'(m_ovf));
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    function automatic int ones(input int frame);
        int c = 0;
        for (int i = 0; i < OSR; i++) if (bits[frame * OSR + i] == 1) c++;
        return c;
    endfunction

    task automatic wait_tick(input int k);
        int n = 0;
        while (m_ticks <= k && n < 20000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (m_ticks <= k) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_tick: got %0d ticks expected more than %0d", m_ticks, k);
        end
    endtask

    task automatic wait_pdm_high();
        int n = 0;
        while (pdm !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_pdm_high", 32'(pdm), 1);
    endtask

    task automatic push(input logic [15:0] d);
        @(negedge clk);
        data  = d;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic restart();
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        #1;
    endtask

    int exp_alt[4];
    int exp_c0[4];

    initial begin
        exp_alt = '{0, 1, 0, 1};
        exp_c0  = '{0, 1, 1, 1};
        rst_ni = 1'b0;
        en     = 1'b0;
        valid  = 1'b0;
        data   = 16'h0000;
        clr    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_pdm",   32'(pdm),    0);
        check("rst_sd",    32'(aud_sd), 0);
        check("rst_ready", 32'(ready),  0);
        check("rst_level", 32'(level),  0);
        check("rst_unf",   32'(unf),    0);
        check("rst_ovf",   32'(ovf),    0);
        rst_ni = 1'b1;

        // Writes in MUTE are ignored and raise no flag
        push(16'h1111);
        #1;
        check("mute_ovf",   32'(ovf),   0);
        check("mute_level", 32'(level), 0);

        // Silence: PRIME and RUN both alternate 0,1
        restart();
        check("s1_sd_on", 32'(aud_sd), 1);
        for (int i = 0; i < 4; i++) begin
            push(16'h0000);
            repeat (10) @(negedge clk);
        end
        #1;
        check("s1_level4", 32'(level), 4);
        wait_tick(3);
        for (int i = 0; i < 4; i++) check("s1_prime_bit", 32'(bits[i]), 32'(exp_alt[i]));
        wait_tick(63);
        check("s1_pop_level3", 32'(level), 3);
        wait_tick(67);
        for (int i = 0; i < 4; i++) check("s1_run_bit", 32'(bits[64 + i]), 32'(exp_alt[i]));

        // 0x4000 -> 0,1,1,1 and 48 ones per frame; then underrun holds u_cur
        restart();
        for (int i = 0; i < 4; i++) push(16'h4000);
        #1;
        check("s2_level4", 32'(level), 4);
        check("s2_ready0", 32'(ready), 0);
        wait_tick(67);
        for (int i = 0; i < 4; i++) check("s2_bit", 32'(bits[64 + i]), 32'(exp_c0[i]));
        wait_tick(127);
        check("s2_ones_f1", 32'(ones(1)), 48);
        wait_tick(318);
        check("s2_unf_before", 32'(unf), 0);
        wait_tick(319);
        check("s2_unf_set", 32'(unf), 1);
        wait_tick(383);
        check("s2_ones_f5", 32'(ones(5)), 48);

        // Full-scale negative then full-scale positive
        restart();
        check("s3_unf_cleared", 32'(unf), 0);
        push(16'h8000);
        push(16'h7FFF);
        wait_tick(127);
        check("s3_ones_min", 32'(ones(1)), 0);
        wait_tick(191);
        check("s3_first_bit", 32'(bits[128]), 0);
        check("s3_ones_max", 32'(ones(2)), 63);

        // No early pop below PRIME_LEVEL, overflow on 5th sample, set beats clear
        restart();
        push(16'h1234);
        wait_tick(65);
        check("s4_level1", 32'(level), 1);
        check("s4_bit64",  32'(bits[64]), 0);
        check("s4_bit65",  32'(bits[65]), 1);
        @(negedge clk);
        valid = 1'b1;
        data  = 16'h2000;
        @(negedge clk);
        data  = 16'h2001;
        @(negedge clk);
        data  = 16'h2002;
        @(negedge clk);
        #1;
        check("s4_full_ready", 32'(ready), 0);
        check("s4_full_ovf",   32'(ovf),   0);
        check("s4_full_level", 32'(level), 4);
        data = 16'h2003;
        @(negedge clk);
        valid = 1'b0;
        #1;
        check("s4_ovf_set",   32'(ovf),   1);
        check("s4_level_kept", 32'(level), 4);
        @(negedge clk);
        valid = 1'b1;
        clr   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        clr   = 1'b0;
        #1;
        check("s4_set_wins", 32'(ovf), 1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("s4_ovf_clr", 32'(ovf), 0);

        // Drop enable mid-frame in RUN
        wait_tick(130);
        check("s5_level3", 32'(level), 3);
        wait_pdm_high();
        en = 1'b0;
        @(negedge clk);
        #1;
        check("s5_off_pdm",   32'(pdm),    0);
        check("s5_off_sd",    32'(aud_sd), 0);
        check("s5_off_level", 32'(level),  0);
        check("s5_off_ready", 32'(ready),  0);

        // Asynchronous reset between clock edges
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            data  = 16'h3000 + 16'(i);
            valid = 1'b1;
            @(negedge clk);
        end
        valid = 1'b0;
        #1;
        check("s6_pre_ovf",   32'(ovf),   1);
        check("s6_pre_level", 32'(level), 4);
        wait_pdm_high();
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check("s6_arst_pdm",   32'(pdm),    0);
        check("s6_arst_sd",    32'(aud_sd), 0);
        check("s6_arst_ready", 32'(ready),  0);
        check("s6_arst_level", 32'(level),  0);
        check("s6_arst_ovf",   32'(ovf),    0);
        check("s6_arst_unf",   32'(unf),    0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
